// File: rtl/multicycle_ctrl.sv
// One-hot multicycle control unit for the 16-opcode accumulator/stack CPU, with memory wait states, stall timeout and latched TRAP.
// Define CTRL_RETIRE_CNT_EN to build the retired-instruction counter; otherwise Retired is tied to zero.
module multicycle_ctrl #(
  parameter int OP_W     = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [OP_W-1:0]  Op,
  input  logic             LMC,
  input  logic             Perform,
  input  logic             MRDY,
  output logic             PCW,
  output logic             Jump,
  output logic             MW,
  output logic             LM,
  output logic             IW,
  output logic             IorD,
  output logic             MSrc,
  output logic             RW,
  output logic             SrcB,
  output logic             FU,
  output logic             SPW,
  output logic             SPIorD,
  output logic [2:0]       RWSrc,
  output logic [2:0]       ALUOp,
  output logic [8:0]       S,
  output logic             Trap,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [8:0] {
    ST_FETCH  = 9'h001,
    ST_DECODE = 9'h002,
    ST_LOAD   = 9'h004,
    ST_CALC   = 9'h008,
    ST_MEMW   = 9'h010,
    ST_COPY   = 9'h020,
    ST_JUMP   = 9'h040,
    ST_POP    = 9'h080,
    ST_TRAP   = 9'h100
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDI = 4'h1, OP_STO  = 4'h2, OP_SUB  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5, OP_CP   = 4'h6, OP_AND  = 4'h8, OP_XOR  = 4'h9;
  localparam logic [3:0] OP_PUSH = 4'hA, OP_POP  = 4'hB, OP_OR   = 4'hC, OP_ORI  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE, OP_J    = 4'hF;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       stall;
  logic [3:0] o;
  logic       hi_bad;
  logic       lmc_op, calc_op, memw_op, jump_op;

  assign o = Op[3:0];

  generate
    if (OP_W > 4) begin : g_hi
      assign hi_bad = |Op[OP_W-1:4];
    end else begin : g_nohi
      assign hi_bad = 1'b0;
    end
  endgenerate

  // Opcode classes: which states each instruction may legally occupy
  always_comb begin
    lmc_op  = o inside {OP_ADD, OP_STO, OP_SUB, OP_CMP, OP_CP, OP_AND, OP_XOR, OP_OR, OP_JR};
    calc_op = o inside {OP_ADD, OP_ADDI, OP_SUB, OP_CMP, OP_AND, OP_XOR, OP_OR, OP_ORI};
    memw_op = o inside {OP_STO, OP_PUSH};
    jump_op = o inside {OP_JR, OP_J};
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      ST_FETCH: begin
        if (!Perform)  state_nxt = ST_TRAP;
        else if (MRDY) state_nxt = ST_DECODE;
        else           stall     = 1'b1;
      end
      ST_DECODE: begin
        if (!Perform)              state_nxt = ST_FETCH;
        else if (hi_bad)           state_nxt = ST_TRAP;
        else if (LMC && lmc_op)    state_nxt = ST_LOAD;
        else if (calc_op)          state_nxt = ST_CALC;
        else if (memw_op)          state_nxt = ST_MEMW;
        else if (o == OP_CP)       state_nxt = ST_COPY;
        else if (jump_op)          state_nxt = ST_JUMP;
        else if (o == OP_POP)      state_nxt = ST_POP;
        else                       state_nxt = ST_FETCH;
      end
      ST_LOAD: begin
        if (!Perform || hi_bad || !lmc_op) state_nxt = ST_TRAP;
        else if (MRDY) begin
          if (o == OP_STO)     state_nxt = ST_MEMW;
          else if (o == OP_CP) state_nxt = ST_COPY;
          else if (o == OP_JR) state_nxt = ST_JUMP;
          else                 state_nxt = ST_CALC;
        end else stall = 1'b1;
      end
      ST_CALC: state_nxt = (!Perform || hi_bad || !calc_op) ? ST_TRAP : ST_FETCH;
      ST_MEMW: begin
        if (!Perform || hi_bad || !memw_op) state_nxt = ST_TRAP;
        else if (MRDY)                      state_nxt = ST_FETCH;
        else                                stall     = 1'b1;
      end
      ST_COPY: state_nxt = (!Perform || hi_bad || o != OP_CP)  ? ST_TRAP : ST_FETCH;
      ST_JUMP: state_nxt = (!Perform || hi_bad || !jump_op)    ? ST_TRAP : ST_FETCH;
      ST_POP:  state_nxt = (!Perform || hi_bad || o != OP_POP) ? ST_TRAP : ST_FETCH;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_TRAP;
    endcase
    // MRDY=1 on the last allowed stall cycle completes the access instead
    if (stall && wait_cnt == WAIT_LAST) state_nxt = ST_TRAP;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= '0;
      else if (stall)         wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge CLK) begin
    if (RESET) retired_q <= '0;
    else if (state_nxt == ST_FETCH && state != ST_FETCH) retired_q <= retired_q + CNT_W'(1);
  end

  assign Retired = retired_q;
`else
  assign Retired = '0;
`endif

  logic f, d, l, c, m, p, j, q, live;

  assign S    = state;
  assign Trap = state[8];
  assign f    = state[0];
  assign d    = state[1];
  assign l    = state[2];
  assign c    = state[3];
  assign m    = state[4];
  assign p    = state[5];
  assign j    = state[6];
  assign q    = state[7];
  assign live = ~state[8];

  // Strobes are forced low whenever the TRAP bit is set
  always_comb begin
    PCW    = live & ((f & MRDY) | (d & (o == OP_J)) | j);
    Jump   = live & j;
    MW     = live & m & MRDY;
    IW     = live & d;
    LM     = live & ((d & o[1] & o[0]) | l);
    IorD   = live & (f | (d & o[2]));
    MSrc   = live & (l | ~o[3]);
    RW     = live & ((d & o[1] & o[0] & ~o[3]) | p | (j & LMC & o[0]) | (c & ~(o[0] & o[2] & ~o[3])));
    RWSrc  = live ? {d, o[0] & o[2], ~c} : 3'b000;
    ALUOp  = live ? {o[3], o[2], o[0]} : 3'b000;
    SrcB   = live & (o[3] == o[2]) & o[0];
    FU     = live & c & (o == OP_CMP);
    SPW    = live & (q | (d & (o == OP_PUSH)));
    SPIorD = live & q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized run against an instruction-route reference model.
module tb_multicycle_ctrl;
  localparam int OP_W = 6, WAIT_MAX = 4, CNT_W = 4;
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_LOAD = 2, PH_CALC = 3, PH_MEMW = 4,
                 PH_COPY = 5, PH_JUMP = 6, PH_POP = 7, PH_TRAP = 8;
`ifdef CTRL_RETIRE_CNT_EN
  localparam bit RET_ON = 1'b1;
`else
  localparam bit RET_ON = 1'b0;
`endif

  logic CLK = 1'b0, RESET = 1'b1, LMC = 1'b0, Perform = 1'b1, MRDY = 1'b0;
  logic [OP_W-1:0] Op = '0;
  logic PCW, Jump, MW, LM, IW, IorD, MSrc, RW, SrcB, FU, SPW, SPIorD, Trap;
  logic [2:0] RWSrc, ALUOp;
  logic [8:0] S;
  logic [CNT_W-1:0] Retired;
  logic [17:0] strobes;
  int vectors = 0, miscompares = 0;

  assign strobes = {PCW, Jump, MW, LM, IW, IorD, MSrc, RW, SrcB, FU, SPW, SPIorD, RWSrc, ALUOp};

  multicycle_ctrl #(.OP_W(OP_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .Op(Op), .LMC(LMC), .Perform(Perform), .MRDY(MRDY),
    .PCW(PCW), .Jump(Jump), .MW(MW), .LM(LM), .IW(IW), .IorD(IorD), .MSrc(MSrc), .RW(RW),
    .SrcB(SrcB), .FU(FU), .SPW(SPW), .SPIorD(SPIorD), .RWSrc(RWSrc), .ALUOp(ALUOp),
    .S(S), .Trap(Trap), .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  task automatic apply(input logic r, input logic [OP_W-1:0] op, input logic lmc, input logic perf, input logic mrdy);
    @(negedge CLK);
    RESET = r; Op = op; LMC = lmc; Perform = perf; MRDY = mrdy;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
  endtask

  task automatic do_reset();
    apply(1'b1, '0, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  // Reference model: instruction routes through the phases after DECODE
  function automatic int exec_of(input logic [3:0] o);
    case (o)
      4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD: return PH_CALC;
      4'h2, 4'hA: return PH_MEMW;
      4'h6:       return PH_COPY;
      4'hE, 4'hF: return PH_JUMP;
      4'hB:       return PH_POP;
      default:    return -1;
    endcase
  endfunction

  function automatic bit needs_load(input logic [3:0] o);
    return o inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hC, 4'hE};
  endfunction

  function automatic logic [17:0] exp_strobes(input int ph, input logic [3:0] o, input logic lmc, input logic mrdy);
    logic f, d, l, c, m, p, j, q, rw;
    f = (ph == PH_FETCH); d = (ph == PH_DECODE); l = (ph == PH_LOAD); c = (ph == PH_CALC);
    m = (ph == PH_MEMW);  p = (ph == PH_COPY);   j = (ph == PH_JUMP); q = (ph == PH_POP);
    if (ph == PH_TRAP) return '0;
    rw = (d & o[1] & o[0] & ~o[3]) | p | (j & lmc & o[0]) | (c & ~(o[0] & o[2] & ~o[3]));
    return {(f & mrdy) | (d & (o == 4'hF)) | j, j, m & mrdy, (d & o[1] & o[0]) | l, d,
            f | (d & o[2]), l | ~o[3], rw, (o[3] == o[2]) & o[0], c & (o == 4'h5),
            q | (d & (o == 4'hA)), q, d, o[0] & o[2], ~c, o[3], o[2], o[0]};
  endfunction

  task automatic test_reset();
    apply(1'b1, 6'h00, 1'b0, 1'b1, 1'b0); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if (S !== 9'h001) begin miscompares++; $display("FAIL reset_S: got %h expected 001", S); end
    vectors++; if (Trap !== 1'b0) begin miscompares++; $display("FAIL reset_Trap: got %b expected 0", Trap); end
    vectors++; if (strobes !== 18'b000001100000_001_000) begin miscompares++; $display("FAIL reset_strobes: got %b expected 000001100000001000", strobes); end
    vectors++; if (Retired !== '0) begin miscompares++; $display("FAIL reset_Retired: got %0d expected 0", Retired); end
    tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick();
    apply(1'b1, 6'h00, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick(); end
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    vectors++; if (PCW !== 1'b1) begin miscompares++; $display("FAIL reset_midstall_PCW: got %b expected 1", PCW); end
    tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    vectors++; if (S !== 9'h002) begin miscompares++; $display("FAIL reset_midstall_S: got %h expected 002", S); end
  endtask

  task automatic test_add();
    logic [8:0] exp_s [4];
    exp_s = '{9'h001, 9'h002, 9'h008, 9'h001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 6'h00, 1'b0, 1'b1, i < 3);
      vectors++; if (S !== exp_s[i]) begin miscompares++; $display("FAIL add_S%0d: got %h expected %h", i, S, exp_s[i]); end
      if (i == 2) begin
        vectors++; if ({RW, RWSrc} !== 4'b1000) begin miscompares++; $display("FAIL add_RW_RWSrc: got %b expected 1000", {RW, RWSrc}); end
      end
      if (i < 3) tick();
    end
    vectors++; if (Retired !== CNT_W'(RET_ON)) begin miscompares++; $display("FAIL add_Retired: got %0d expected %0d", Retired, RET_ON); end
  endtask

  task automatic test_sto_wait();
    logic [8:0] sched = 9'b100100011;
    logic [8:0] exp_s [9];
    int lm_cnt = 0, mw_cnt = 0;
    exp_s = '{9'h001, 9'h002, 9'h004, 9'h004, 9'h004, 9'h004, 9'h010, 9'h010, 9'h010};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 6'h02, 1'b1, 1'b1, sched[i]);
      vectors++; if (S !== exp_s[i]) begin miscompares++; $display("FAIL sto_S%0d: got %h expected %h", i, S, exp_s[i]); end
      lm_cnt += int'(LM);
      mw_cnt += int'(MW);
      tick();
    end
    apply(1'b0, 6'h02, 1'b1, 1'b1, 1'b0);
    vectors++; if (S !== 9'h001) begin miscompares++; $display("FAIL sto_latency: got %h expected 001", S); end
    vectors++; if (lm_cnt !== 4) begin miscompares++; $display("FAIL sto_LM_cycles: got %0d expected 4", lm_cnt); end
    vectors++; if (mw_cnt !== 1) begin miscompares++; $display("FAIL sto_MW_pulses: got %0d expected 1", mw_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) begin apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick(); end
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    vectors++; if (S !== 9'h002) begin miscompares++; $display("FAIL timeout_lastcycle_win: got %h expected 002", S); end
    do_reset();
    for (int i = 0; i < 4; i++) begin apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick(); end
    for (int i = 0; i < 11; i++) begin
      apply(1'b0, 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++; if ({S, Trap} !== {9'h100, 1'b1}) begin miscompares++; $display("FAIL timeout_trap%0d: got S=%h Trap=%b expected S=100 Trap=1", i, S, Trap); end
      vectors++; if (strobes !== '0) begin miscompares++; $display("FAIL timeout_strobes%0d: got %b expected 0", i, strobes); end
      tick();
    end
    apply(1'b1, 6'h00, 1'b0, 1'b1, 1'b0); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if ({S, Trap} !== {9'h001, 1'b0}) begin miscompares++; $display("FAIL timeout_reset: got S=%h Trap=%b expected S=001 Trap=0", S, Trap); end
  endtask

  task automatic test_perform();
    do_reset();
    apply(1'b0, 6'h0F, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h0F, 1'b0, 1'b0, 1'b1); tick();
    apply(1'b0, 6'h0F, 1'b0, 1'b1, 1'b0);
    vectors++; if ({S, Jump} !== {9'h001, 1'b0}) begin miscompares++; $display("FAIL perform_skip: got S=%h Jump=%b expected S=001 Jump=0", S, Jump); end
    vectors++; if (Retired !== CNT_W'(RET_ON)) begin miscompares++; $display("FAIL perform_skip_Retired: got %0d expected %0d", Retired, RET_ON); end
    do_reset();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b0, 1'b1); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    vectors++; if (S !== 9'h100) begin miscompares++; $display("FAIL perform_calc_trap: got %h expected 100", S); end
    do_reset();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h00, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h02, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h02, 1'b0, 1'b1, 1'b1);
    vectors++; if (S !== 9'h100) begin miscompares++; $display("FAIL illegal_in_calc: got %h expected 100", S); end
  endtask

  task automatic test_opw();
    do_reset();
    apply(1'b0, 6'h10, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h10, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h10, 1'b0, 1'b1, 1'b1);
    vectors++; if (S !== 9'h100) begin miscompares++; $display("FAIL opw_high_bits: got %h expected 100", S); end
    do_reset();
    apply(1'b0, 6'h0F, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 6'h0F, 1'b0, 1'b1, 1'b1);
    vectors++; if ({S, PCW, Jump} !== {9'h002, 1'b1, 1'b0}) begin miscompares++; $display("FAIL opw_J_decode: got S=%h PCW=%b Jump=%b expected S=002 PCW=1 Jump=0", S, PCW, Jump); end
    tick();
    apply(1'b0, 6'h0F, 1'b0, 1'b1, 1'b1);
    vectors++; if ({S, PCW, Jump} !== {9'h040, 1'b1, 1'b1}) begin miscompares++; $display("FAIL opw_J_jump: got S=%h PCW=%b Jump=%b expected S=040 PCW=1 Jump=1", S, PCW, Jump); end
    tick();
    apply(1'b0, 6'h0F, 1'b0, 1'b1, 1'b0);
    vectors++; if (S !== 9'h001) begin miscompares++; $display("FAIL opw_J_done: got %h expected 001", S); end
  endtask

  task automatic test_retire_wrap();
    logic [CNT_W-1:0] exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      apply(1'b0, 6'h03, 1'b0, 1'b1, 1'b1); tick();
      apply(1'b0, 6'h03, 1'b0, 1'b1, 1'b1); tick();
      apply(1'b0, 6'h03, 1'b0, 1'b1, 1'b0);
      exp = RET_ON ? CNT_W'(k % 16) : '0;
      vectors++; if (Retired !== exp) begin miscompares++; $display("FAIL retire_lui%0d: got %0d expected %0d", k, Retired, exp); end
    end
  endtask

  task automatic test_random();
    int ph = PH_FETCH, nph, wcnt = 0, ret = 0;
    logic r, lmc = 1'b0, perf, mrdy, stalled, hb;
    logic [OP_W-1:0] op = '0;
    logic [3:0] o;
    logic [17:0] es;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = (ph == PH_TRAP && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0;
      if ((ph == PH_FETCH && $urandom_range(0, 2) == 0) || $urandom_range(0, 49) == 0) begin
        op  = {($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 4'($urandom_range(0, 15))};
        lmc = 1'($urandom);
      end
      perf = $urandom_range(0, 29) != 0;
      mrdy = $urandom_range(0, 3) != 0;
      apply(r, op, lmc, perf, mrdy);
      o  = op[3:0];
      hb = |op[OP_W-1:4];
      es = exp_strobes(ph, o, lmc, mrdy);
      vectors++; if (S !== 9'(1 << ph)) begin miscompares++; $display("FAIL rand_S@%0d: got %h expected %h", n, S, 9'(1 << ph)); end
      vectors++; if (Trap !== (ph == PH_TRAP)) begin miscompares++; $display("FAIL rand_Trap@%0d: got %b expected %b", n, Trap, ph == PH_TRAP); end
      vectors++; if (strobes !== es) begin miscompares++; $display("FAIL rand_strobes@%0d: got %b expected %b", n, strobes, es); end
      vectors++; if (Retired !== (RET_ON ? CNT_W'(ret) : CNT_W'(0))) begin miscompares++; $display("FAIL rand_Retired@%0d: got %0d expected %0d", n, Retired, RET_ON ? CNT_W'(ret) : CNT_W'(0)); end
      stalled = 1'b0;
      nph = ph;
      if (r)                    nph = PH_FETCH;
      else if (ph == PH_TRAP)   nph = PH_TRAP;
      else if (!perf)           nph = (ph == PH_DECODE) ? PH_FETCH : PH_TRAP;
      else if (ph == PH_FETCH) begin
        if (mrdy) nph = PH_DECODE; else stalled = 1'b1;
      end else if (ph == PH_DECODE) begin
        if (hb)                          nph = PH_TRAP;
        else if (lmc && needs_load(o))   nph = PH_LOAD;
        else if (exec_of(o) >= 0)        nph = exec_of(o);
        else                             nph = PH_FETCH;
      end else if (hb || (ph == PH_LOAD ? !needs_load(o) : ph != exec_of(o))) nph = PH_TRAP;
      else if ((ph == PH_LOAD || ph == PH_MEMW) && !mrdy) stalled = 1'b1;
      else nph = (ph == PH_LOAD) ? exec_of(o) : PH_FETCH;
      if (stalled && wcnt == WAIT_MAX - 1) nph = PH_TRAP;
      if (r) ret = 0;
      else if (nph == PH_FETCH && ph != PH_FETCH) ret++;
      if (r || nph != ph) wcnt = 0;
      else if (stalled)   wcnt++;
      ph = nph;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sto_wait();
    test_timeout();
    test_perform();
    test_opw();
    test_retire_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
